// File: rtl/mux_rr_scheduler_pkg.sv
// Shared constants and types for the round-robin mux scheduler.
// The optional burst lock is enabled by defining MUX_SCHED_LOCK_EN.
package mux_sched_pkg;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;
   localparam int SEL_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      HOLD = 2'd2
   } sched_state_e;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [DEPTH-1:0] vec_t;
   typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Requester/consumer bus of the mux scheduler; MUX_SCHED_LOCK_EN adds the lock vector.
// Handshake: cout is consumed on a rising clk edge where out_valid && out_ready;
// cout/out_valid stay stable while out_ready is low, and out_valid never depends on out_ready.
interface mux_rr_scheduler_if;
   import mux_sched_pkg::*;

   vec_t         req;
   word_t        din [DEPTH];
   logic         out_ready;
`ifdef MUX_SCHED_LOCK_EN
   vec_t         lock;
`endif
   sel_t         sel;
   vec_t         grant;
   vec_t         ack;
   word_t        cout;
   logic         out_valid;
   sched_state_e dbg_state;

`ifdef MUX_SCHED_LOCK_EN
   modport master (output req, din, out_ready, lock,
                   input  sel, grant, ack, cout, out_valid, dbg_state);
   modport slave  (input  req, din, out_ready, lock,
                   output sel, grant, ack, cout, out_valid, dbg_state);
`else
   modport master (output req, din, out_ready,
                   input  sel, grant, ack, cout, out_valid, dbg_state);
   modport slave  (input  req, din, out_ready,
                   output sel, grant, ack, cout, out_valid, dbg_state);
`endif

endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping modulo DEPTH.
module rr_pick
   import mux_sched_pkg::*;
(
   input  vec_t req_i,
   input  sel_t ptr_i,
   output sel_t winner_o,
   output vec_t onehot_o,
   output logic any_o
);

   int idx;

   // Scan from the farthest candidate back to the nearest so the nearest hit wins.
   always_comb begin
      winner_o = '0;
      idx      = 0;
      any_o    = |req_i;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         idx = (int'(ptr_i) + i + 1) % DEPTH;
         if (req_i[idx]) winner_o = sel_t'(idx);
      end
      onehot_o = any_o ? (vec_t'(1) << winner_o) : '0;
   end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing a DEPTH:1 word mux; captures the winner's word into a
// registered valid/ready output. Build with MUX_SCHED_LOCK_EN for locked bursts.
module mux_rr_scheduler
   import mux_sched_pkg::*;
(
   input logic               clk,
   input logic               rst,
   mux_rr_scheduler_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEL  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0] state_q, state_d;
   sel_t       sel_q, sel_d;
   sel_t       rr_ptr_q, rr_ptr_d;
   vec_t       grant_q, grant_d;
   vec_t       ack_q, ack_d;
   word_t      cout_q, cout_d;
   logic       out_valid_q, out_valid_d;

   sel_t       pick_ptr;
   sel_t       pick_win;
   vec_t       pick_oh;
   logic       pick_any;
   logic       burst;

   // In HOLD the next winner is searched from the word being retired, not the stored pointer.
   assign pick_ptr = (state_q == S_HOLD) ? sel_q : rr_ptr_q;

   rr_pick u_pick (
      .req_i    (bus.req),
      .ptr_i    (pick_ptr),
      .winner_o (pick_win),
      .onehot_o (pick_oh),
      .any_o    (pick_any)
   );

`ifdef MUX_SCHED_LOCK_EN
   assign burst = bus.lock[sel_q] && bus.req[sel_q];
`else
   assign burst = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      ack_d       = '0;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (pick_any) begin
               sel_d   = pick_win;
               grant_d = pick_oh;
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            if (bus.req[sel_q]) begin
               cout_d      = bus.din[sel_q];
               out_valid_d = 1'b1;
               ack_d       = grant_q;
               state_d     = S_HOLD;
            end else begin
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               if (burst) begin
                  state_d = S_SEL;
               end else begin
                  rr_ptr_d = sel_q;
                  if (pick_any) begin
                     sel_d   = pick_win;
                     grant_d = pick_oh;
                     state_d = S_SEL;
                  end else begin
                     grant_d = '0;
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: begin
            grant_d     = '0;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         rr_ptr_q    <= sel_t'(DEPTH - 1);
         grant_q     <= '0;
         ack_q       <= '0;
         cout_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.grant     = grant_q;
   assign bus.ack       = ack_q;
   assign bus.cout      = cout_q;
   assign bus.out_valid = out_valid_q;
   assign bus.dbg_state = sched_state_e'(state_q);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: directed scenarios plus random traffic against a
// transaction-level model. Define MUX_SCHED_LOCK_EN to cover the burst lock.
module tb_mux_rr_scheduler;
   import mux_sched_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic [31:0] exp_q[$];

   mux_rr_scheduler_if bus ();

   mux_rr_scheduler dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   // ---------------- clock / cycle counter
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model: who owns the mux, whether a word is held
   int    m_ptr = DEPTH - 1;
   int    m_owner = -1;
   bit    m_have_word = 1'b0;
   int    m_sel = 0;
   int    m_ack = -1;
   word_t m_cout = '0;

   function automatic int pick(logic [DEPTH-1:0] r, int ptr);
      for (int k = 1; k <= DEPTH; k++) begin
         int i;
         i = (ptr + k) % DEPTH;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic bit lock_holds(int who);
`ifdef MUX_SCHED_LOCK_EN
      return bus.lock[who] && bus.req[who];
`else
      return (who < 0);
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr = DEPTH - 1; m_owner = -1; m_have_word = 1'b0;
         m_sel = 0; m_ack = -1; m_cout = '0;
      end else begin
         m_ack = -1;
         if (m_owner < 0) begin
            m_owner = pick(bus.req, m_ptr);
            if (m_owner >= 0) m_sel = m_owner;
         end else if (!m_have_word) begin
            if (bus.req[m_owner]) begin
               m_cout = bus.din[m_owner];
               m_have_word = 1'b1;
               m_ack = m_owner;
            end else begin
               m_owner = -1;
            end
         end else if (bus.out_ready) begin
            m_have_word = 1'b0;
            if (!lock_holds(m_owner)) begin
               m_ptr = m_owner;
               m_owner = pick(bus.req, m_ptr);
               if (m_owner >= 0) m_sel = m_owner;
            end
         end
      end
   end

   // ---------------- checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_sel", 32'(bus.sel), 32'(m_sel));
      check("model_grant", 32'(bus.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("model_ack", 32'(bus.ack), (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
      check("model_cout", bus.cout, m_cout);
      check("model_valid", 32'(bus.out_valid), 32'(m_have_word));
      check("ack_in_grant", 32'(bus.ack & ~bus.grant), 32'd0);
   end

   // ---------------- driver tasks
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req = '1;
      bus.out_ready = 1'b0;
`ifdef MUX_SCHED_LOCK_EN
      bus.lock = '0;
`endif
      repeat (2) tick();
      check("rst_sel", 32'(bus.sel), 32'd0);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_cout", bus.cout, 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
      rst_n = 1'b1;
      bus.req = '0;
   endtask

   // ---------------- stimulus
   initial begin
      int acks;
      int last_cyc;
      logic [31:0] got;

      bus.req = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) bus.din[i] = '0;
`ifdef MUX_SCHED_LOCK_EN
      bus.lock = '0;
`endif
      #1 rst_n = 1'b0;

      // 1: reset with all requests, then a single request on 3
      do_reset();
      bus.req = 16'h0008;
      bus.din[3] = 32'hA5A5_0003;
      bus.out_ready = 1'b1;
      tick();
      check("t1_sel_grant", 32'(bus.grant), 32'h0008);
      check("t1_valid_early", 32'(bus.out_valid), 32'd0);
      tick();
      check("t1_valid", 32'(bus.out_valid), 32'd1);
      check("t1_cout", bus.cout, 32'hA5A5_0003);
      check("t1_ack", 32'(bus.ack), 32'h0008);
      check("t1_sel", 32'(bus.sel), 32'd3);
      bus.req = '0;
      repeat (3) tick();

      // 2: all requesting, strictly cyclic service, one word per two cycles
      do_reset();
      for (int i = 0; i < DEPTH; i++) bus.din[i] = 32'(i);
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'(i));
      exp_q.push_back(32'd0);
      bus.req = 16'hFFFF;
      bus.out_ready = 1'b1;
      last_cyc = -1;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         tick();
         if (bus.ack != '0) begin
            got = exp_q.pop_front();
            check("t2_order", bus.cout, got);
            if (last_cyc >= 0) check("t2_spacing", 32'(cyc - last_cyc), 32'd2);
            last_cyc = cyc;
         end
      end
      check("t2_all_served", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      bus.req = '0;
      repeat (3) tick();

      // 3: backpressure holds the word and gives exactly one ack
      do_reset();
      bus.req = 16'h0020;
      bus.din[5] = 32'h5555_0005;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      check("t3_valid", 32'(bus.out_valid), 32'd1);
      acks = (bus.ack == 16'h0020) ? 1 : 0;
      repeat (6) begin
         tick();
         check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
         check("t3_hold_cout", bus.cout, 32'h5555_0005);
         if (bus.ack != '0) acks++;
      end
      check("t3_ack_count", 32'(acks), 32'd1);
      bus.out_ready = 1'b1;
      bus.req = '0;
      tick();
      check("t3_idle_valid", 32'(bus.out_valid), 32'd0);
      check("t3_idle_grant", 32'(bus.grant), 32'd0);
      check("t3_idle_state", 32'(bus.dbg_state), 32'(IDLE));

      // 4: abort leaves the pointer alone, so 2 beats 9
      do_reset();
      bus.out_ready = 1'b1;
      bus.req = 16'h0080;
      tick();
      check("t4_grant7", 32'(bus.grant), 32'h0080);
      bus.req = '0;
      tick();
      check("t4_abort_grant", 32'(bus.grant), 32'd0);
      check("t4_abort_valid", 32'(bus.out_valid), 32'd0);
      check("t4_abort_ack", 32'(bus.ack), 32'd0);
      bus.req = 16'h0204;
      tick();
      check("t4_sel2", 32'(bus.sel), 32'd2);
      bus.req = '0;
      repeat (3) tick();

      // 5: wrap from 15 to 0, then asynchronous reset during HOLD
      do_reset();
      bus.out_ready = 1'b1;
      bus.req = 16'h8000;
      repeat (2) tick();
      check("t5_served15", 32'(bus.ack), 32'h8000);
      bus.req = 16'h4001;
      tick();
      check("t5_wrap_sel", 32'(bus.sel), 32'd0);
      bus.out_ready = 1'b0;
      repeat (2) tick();
      check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
      check("t5_rst_ack", 32'(bus.ack), 32'd0);
      check("t5_rst_grant", 32'(bus.grant), 32'd0);
      tick();
      rst_n = 1'b1;
      bus.req = '0;
      tick();

`ifdef MUX_SCHED_LOCK_EN
      // 6: lock on 4 gives a three-beat burst before 6 is served
      do_reset();
      bus.out_ready = 1'b1;
      bus.req = 16'h0050;
      bus.lock = 16'h0010;
      exp_q.push_back(32'd4); exp_q.push_back(32'd4);
      exp_q.push_back(32'd4); exp_q.push_back(32'd6);
      acks = 0;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         tick();
         if (bus.ack != '0) begin
            got = exp_q.pop_front();
            check("t6_burst", 32'(bus.sel), got);
            acks++;
            if (acks == 3) bus.lock = '0;
         end
      end
      check("t6_all_served", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      bus.req = '0;
      repeat (3) tick();
`endif

      // random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.req = ($urandom_range(0, 7) == 0) ? '0 : vec_t'($urandom() & $urandom());
         bus.out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < DEPTH; i++) bus.din[i] = $urandom();
`ifdef MUX_SCHED_LOCK_EN
         bus.lock = vec_t'($urandom() & $urandom());
`endif
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
